// File: rtl/lc3b_types.sv
// Shared LC-3b types: datapath word, opcode encodings, store mask and
// the MEM-stage memory sequencer state.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;
    typedef logic [1:0]  lc3b_mem_wmask;

    localparam lc3b_opcode op_br   = 4'b0000;
    localparam lc3b_opcode op_add  = 4'b0001;
    localparam lc3b_opcode op_ldb  = 4'b0010;
    localparam lc3b_opcode op_stb  = 4'b0011;
    localparam lc3b_opcode op_jsr  = 4'b0100;
    localparam lc3b_opcode op_and  = 4'b0101;
    localparam lc3b_opcode op_ldr  = 4'b0110;
    localparam lc3b_opcode op_str  = 4'b0111;
    localparam lc3b_opcode op_rti  = 4'b1000;
    localparam lc3b_opcode op_not  = 4'b1001;
    localparam lc3b_opcode op_ldi  = 4'b1010;
    localparam lc3b_opcode op_sti  = 4'b1011;
    localparam lc3b_opcode op_jmp  = 4'b1100;
    localparam lc3b_opcode op_shf  = 4'b1101;
    localparam lc3b_opcode op_lea  = 4'b1110;
    localparam lc3b_opcode op_trap = 4'b1111;

    typedef enum logic [1:0] {
        S_FIRST  = 2'd0,
        S_SECOND = 2'd1,
        S_DONE   = 2'd2
    } mem_seq_state_t;

    // LDI/STI fetch a pointer before the real access.
    function automatic logic is_indirect(input lc3b_opcode op);
        return (op == op_ldi) || (op == op_sti);
    endfunction

endpackage

// File: rtl/mem_access_sequencer.sv
// MEM-stage data-memory sequencer: one access for plain loads/stores/TRAP,
// pointer read followed by the data access for LDI/STI; stalls until done.
module mem_access_sequencer
    import lc3b_types::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid,
    input  lc3b_opcode        opcode,
    input  logic              read_memory,
    input  logic              write_memory,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  lc3b_mem_wmask     wmask,
    input  logic              advance,
    input  logic              dmem_resp,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [DATA_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_wdata,
    output lc3b_mem_wmask     dmem_wmask,
    output logic [DATA_W-1:0] rdata_out,
    output logic              stall,
    output logic [15:0]       stall_cycles
);

    mem_seq_state_t    r_state, w_next;
    logic [DATA_W-1:0] r_ptr, r_data;
    logic [15:0]       r_stall_cnt;

    logic w_indirect, w_acc, w_is_sti, w_first_acc, w_second;
    logic w_final, w_stall;

    assign w_indirect  = is_indirect(opcode);
    assign w_acc       = valid & (read_memory | write_memory);
    assign w_is_sti    = (opcode == op_sti);
    assign w_first_acc = (r_state == S_FIRST) & w_acc;
    assign w_second    = (r_state == S_SECOND);
    assign w_final     = dmem_resp & ((w_first_acc & ~w_indirect) | w_second);
    assign w_stall     = (w_first_acc | w_second) & ~w_final;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_FIRST;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FIRST: begin
                if (w_acc & dmem_resp)
                    w_next = w_indirect ? S_SECOND : (advance ? S_FIRST : S_DONE);
            end
            S_SECOND: begin
                if (dmem_resp) w_next = advance ? S_FIRST : S_DONE;
            end
            S_DONE: begin
                if (advance) w_next = S_FIRST;
            end
            default: w_next = S_FIRST;
        endcase
    end

    always_comb begin
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_address = '0;
        dmem_wdata   = '0;
        dmem_wmask   = '0;
        rdata_out    = '0;
        stall        = 1'b0;
        stall_cycles = '0;
        if (reset_n) begin
            case (r_state)
                S_FIRST: begin
                    if (w_acc) begin
                        dmem_address = addr;
                        dmem_read    = read_memory | w_indirect;
                        dmem_write   = write_memory & ~w_indirect;
                        dmem_wdata   = wdata;
                        dmem_wmask   = wmask;
                    end
                end
                S_SECOND: begin
                    // Pointer is forced word-aligned for the dependent access.
                    dmem_address = {r_ptr[DATA_W-1:1], 1'b0};
                    if (w_is_sti) begin
                        dmem_write = 1'b1;
                        dmem_wdata = wdata;
                        dmem_wmask = 2'b11;
                    end else begin
                        dmem_read  = 1'b1;
                    end
                end
                default: ;
            endcase
            stall        = w_stall;
            rdata_out    = w_final ? dmem_rdata : r_data;
            stall_cycles = r_stall_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_data      <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_first_acc & w_indirect & dmem_resp)
                r_ptr <= dmem_rdata;
            if (w_final & ~(w_second & w_is_sti))
                r_data <= dmem_rdata;
            if (w_stall && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed scenarios with literal checks,
// then random instruction/response streams against a transaction model.
module tb_mem_access_sequencer;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        reset_n, valid, read_memory, write_memory, advance, dmem_resp;
    logic [3:0]  opcode;
    logic [15:0] addr, wdata, dmem_rdata;
    logic [1:0]  wmask;
    logic        dmem_read, dmem_write, stall;
    logic [15:0] dmem_address, dmem_wdata, rdata_out, stall_cycles;
    logic [1:0]  dmem_wmask;

    int total = 0;
    int bad   = 0;

    mem_access_sequencer #(.DATA_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .opcode(opcode),
        .read_memory(read_memory), .write_memory(write_memory),
        .addr(addr), .wdata(wdata), .wmask(wmask), .advance(advance),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_wmask(dmem_wmask), .rdata_out(rdata_out), .stall(stall),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // Transaction model: which access of the current instruction is pending,
    // whether a finished result is waiting for WB, and the latched values.
    bit          m_second, m_held, m_retired;
    logic [15:0] m_ptr, m_data, m_cnt;

    always @(negedge clk) begin
        logic        e_rd, e_wr, e_st, fin, ind, acc, busy;
        logic [15:0] e_addr, e_wd, e_rdo, e_cnt;
        logic [1:0]  e_wm;
        e_rd = 0; e_wr = 0; e_st = 0; fin = 0; busy = 0;
        e_addr = 0; e_wd = 0; e_wm = 0; e_rdo = 0; e_cnt = 0;
        ind = (opcode == op_ldi) || (opcode == op_sti);
        acc = valid && (read_memory || write_memory);
        m_retired = 0;
        if (reset_n) begin
            e_cnt = m_cnt;
            if (m_second) begin
                busy   = 1;
                e_addr = m_ptr & 16'hFFFE;
                if (opcode == op_sti) begin e_wr = 1; e_wd = wdata; e_wm = 2'b11; end
                else e_rd = 1;
                fin = dmem_resp;
            end else if (!m_held && acc) begin
                busy   = 1;
                e_addr = addr;
                e_rd   = read_memory || ind;
                e_wr   = write_memory && !ind;
                e_wd   = wdata;
                e_wm   = wmask;
                fin    = dmem_resp && !ind;
            end
            e_st  = busy && !fin;
            e_rdo = fin ? dmem_rdata : m_data;
        end
        chk("dmem_read",    {15'd0, dmem_read},  {15'd0, e_rd});
        chk("dmem_write",   {15'd0, dmem_write}, {15'd0, e_wr});
        chk("dmem_address", dmem_address, e_addr);
        chk("dmem_wdata",   dmem_wdata, e_wd);
        chk("dmem_wmask",   {14'd0, dmem_wmask}, {14'd0, e_wm});
        chk("rdata_out",    rdata_out, e_rdo);
        chk("stall",        {15'd0, stall}, {15'd0, e_st});
        chk("stall_cycles", stall_cycles, e_cnt);
        chk("rw_exclusive", {15'd0, dmem_read & dmem_write}, 16'd0);

        if (!reset_n) begin
            m_second = 0; m_held = 0; m_ptr = 0; m_data = 0; m_cnt = 0; m_retired = 1;
        end else begin
            if (e_st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (fin) begin
                if (!m_second || opcode != op_sti) m_data = dmem_rdata;
                m_second = 0;
                if (advance) m_retired = 1; else m_held = 1;
            end else if (m_held) begin
                if (advance) begin m_held = 0; m_retired = 1; end
            end else if (!m_second && acc && ind && dmem_resp) begin
                m_ptr = dmem_rdata; m_second = 1;
            end else if (!m_second && !acc && advance) begin
                m_retired = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drv(input logic v, input logic [3:0] op, input logic rm, input logic wm,
                       input logic [15:0] a, input logic [15:0] wd, input logic [1:0] msk,
                       input logic rsp, input logic [15:0] rd, input logic adv);
        valid = v; opcode = op; read_memory = rm; write_memory = wm; addr = a;
        wdata = wd; wmask = msk; dmem_resp = rsp; dmem_rdata = rd; advance = adv;
    endtask

    initial begin
        reset_n = 0;
        drv(0, op_add, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0, 0);
        @(negedge clk);
        chk("rst_read",  {15'd0, dmem_read}, 16'd0);
        chk("rst_stall", {15'd0, stall}, 16'd0);
        tick(); tick();
        reset_n = 1;
        @(negedge clk);
        chk("idle_cnt",   stall_cycles, 16'd0);
        chk("idle_rdata", rdata_out, 16'd0);
        tick();

        // LDR with response on third cycle
        drv(1, op_ldr, 1, 0, 16'h3000, 16'h0, 2'b11, 0, 16'h0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t1_read", {15'd0, dmem_read}, 16'd1);
            chk("t1_addr", dmem_address, 16'h3000);
            chk("t1_stall", {15'd0, stall}, 16'd1);
            tick();
        end
        dmem_resp = 1; dmem_rdata = 16'h1234; advance = 1;
        @(negedge clk);
        chk("t1_stall_end", {15'd0, stall}, 16'd0);
        chk("t1_rdata", rdata_out, 16'h1234);
        tick();
        drv(0, op_add, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0, 0);
        @(negedge clk);
        chk("t1_cnt", stall_cycles, 16'd2);
        tick();

        // LDI
        drv(1, op_ldi, 1, 0, 16'h4000, 16'h0, 2'b11, 1, 16'h5001, 0);
        @(negedge clk);
        chk("t2_addr1", dmem_address, 16'h4000);
        chk("t2_stall1", {15'd0, stall}, 16'd1);
        tick();
        dmem_resp = 0;
        @(negedge clk);
        chk("t2_addr2", dmem_address, 16'h5000);
        chk("t2_read2", {15'd0, dmem_read}, 16'd1);
        chk("t2_stall2", {15'd0, stall}, 16'd1);
        tick();
        dmem_resp = 1; dmem_rdata = 16'hBEEF; advance = 1;
        @(negedge clk);
        chk("t2_stall3", {15'd0, stall}, 16'd0);
        chk("t2_rdata", rdata_out, 16'hBEEF);
        tick();

        // STI
        drv(1, op_sti, 0, 1, 16'h4000, 16'hCAFE, 2'b01, 1, 16'h6000, 0);
        @(negedge clk);
        chk("t3_read1", {15'd0, dmem_read}, 16'd1);
        chk("t3_write1", {15'd0, dmem_write}, 16'd0);
        chk("t3_addr1", dmem_address, 16'h4000);
        tick();
        dmem_rdata = 16'h0000; advance = 1;
        @(negedge clk);
        chk("t3_write2", {15'd0, dmem_write}, 16'd1);
        chk("t3_read2", {15'd0, dmem_read}, 16'd0);
        chk("t3_addr2", dmem_address, 16'h6000);
        chk("t3_wdata", dmem_wdata, 16'hCAFE);
        chk("t3_wmask", {14'd0, dmem_wmask}, 16'd3);
        tick();

        // STB zero-wait
        drv(1, op_stb, 0, 1, 16'h2001, 16'h00AB, 2'b10, 1, 16'h0, 1);
        @(negedge clk);
        chk("t4_write", {15'd0, dmem_write}, 16'd1);
        chk("t4_addr", dmem_address, 16'h2001);
        chk("t4_wmask", {14'd0, dmem_wmask}, 16'd2);
        chk("t4_stall", {15'd0, stall}, 16'd0);
        tick();

        // LDR held in done state by advance=0
        drv(1, op_ldr, 1, 0, 16'h3000, 16'h0, 2'b11, 1, 16'h4321, 0);
        @(negedge clk);
        chk("t5_rdata0", rdata_out, 16'h4321);
        tick();
        dmem_resp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_noreq", {15'd0, dmem_read | dmem_write}, 16'd0);
            chk("t5_hold", rdata_out, 16'h4321);
            tick();
        end
        advance = 1;
        @(negedge clk);
        chk("t5_adv_noreq", {15'd0, dmem_read}, 16'd0);
        tick();
        addr = 16'h3002; advance = 0;
        @(negedge clk);
        chk("t5_next_read", {15'd0, dmem_read}, 16'd1);
        chk("t5_next_addr", dmem_address, 16'h3002);
        tick();
        dmem_resp = 1; dmem_rdata = 16'h0001; advance = 1;
        tick();

        // reset mid indirect second access
        drv(1, op_ldi, 1, 0, 16'h4000, 16'h0, 2'b11, 1, 16'h7777, 0);
        tick();
        dmem_resp = 0;
        @(negedge clk);
        chk("t6_addr2", dmem_address, 16'h7776);
        tick();
        reset_n = 0; dmem_resp = 1; dmem_rdata = 16'hAAAA;
        @(negedge clk);
        chk("t6_rst_read", {15'd0, dmem_read}, 16'd0);
        chk("t6_rst_stall", {15'd0, stall}, 16'd0);
        tick();
        reset_n = 1; valid = 0; dmem_rdata = 16'h5555;
        @(negedge clk);
        chk("t6_post_read", {15'd0, dmem_read}, 16'd0);
        chk("t6_post_stall", {15'd0, stall}, 16'd0);
        chk("t6_post_cnt", stall_cycles, 16'd0);
        chk("t6_post_rdata", rdata_out, 16'd0);
        tick();
        drv(1, op_ldr, 1, 0, 16'h3000, 16'h0, 2'b11, 1, 16'h1111, 1);
        @(negedge clk);
        chk("t6_ldr_addr", dmem_address, 16'h3000);
        chk("t6_ldr_rdata", rdata_out, 16'h1111);
        tick();

        // random instruction stream
        for (int c = 0; c < 4000; c++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            if (c == 0 || m_retired) begin
                logic       rm, wm;
                logic [3:0] op;
                case ($urandom_range(0, 7))
                    0: begin op = op_ldr;  rm = 1; wm = 0; end
                    1: begin op = op_ldb;  rm = 1; wm = 0; end
                    2: begin op = op_str;  rm = 0; wm = 1; end
                    3: begin op = op_stb;  rm = 0; wm = 1; end
                    4: begin op = op_trap; rm = 1; wm = 0; end
                    5: begin op = op_ldi;  rm = 1; wm = 0; end
                    6: begin op = op_sti;  rm = 0; wm = 1; end
                    default: begin op = op_add; rm = 0; wm = 0; end
                endcase
                valid = ($urandom_range(0, 9) != 0);
                opcode = op; read_memory = rm; write_memory = wm;
                addr = 16'($urandom); wdata = 16'($urandom);
                wmask = 2'($urandom_range(1, 3));
            end
            dmem_resp  = ($urandom_range(0, 2) != 0);
            dmem_rdata = 16'($urandom);
            advance    = ($urandom_range(0, 1) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
